// File: rtl/loopback_seq_if.sv
// loopback_seq_if: control, status and loopback pad bundle of
// the PMOD loopback sequencer.
interface loopback_seq_if;
  logic       start;
  logic       mode;
  logic       abort;
  logic [1:0] rx_data;
  logic [1:0] tx_data;
  logic       sel;
  logic       drive_en;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_cnt;
  logic [2:0] fail_vec;
  logic [3:0] led;

  modport master (
    output start, mode, abort, rx_data,
    input  tx_data, sel, drive_en, busy, done,
    input  pass, err_cnt, fail_vec, led
  );

  modport slave (
    input  start, mode, abort, rx_data,
    output tx_data, sel, drive_en, busy, done,
    output pass, err_cnt, fail_vec, led
  );
endinterface

// File: rtl/loopback_seq.sv
// loopback_seq: self-running stimulus/check sequencer for the
// 2-bit PMOD JC<->JD loopback, with pass/fail LEDs.
module loopback_seq #(
  parameter int SETTLE_CYCLES = 16
) (
  input  logic          clk,
  input  logic          rst,
  loopback_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_DRIVE, S_SETTLE, S_CHECK, S_TURN, S_DONE
  } state_t;

  localparam logic [7:0] LP_LAST = 8'(SETTLE_CYCLES - 1);

  state_t     r_state, w_nxt;
  logic [2:0] r_vec, w_vec_nxt;
  logic [7:0] r_settle;
  logic [1:0] r_rx1, r_rx_s;
  logic       r_start, r_start_d;
  logic [7:0] r_err_cnt;
  logic [2:0] r_fail_vec;
  logic       r_first_err, r_run_err;
  logic       r_pass, r_ran;
  logic [1:0] r_tx;
  logic       r_sel;
  logic       w_start, w_abort, w_mis;

  assign w_start = r_start & ~r_start_d;
  assign w_abort = bus.abort & (r_state != S_IDLE);
  assign w_mis   = r_rx_s != r_vec[1:0];

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_nxt;
  end

  always_comb begin
    w_nxt     = r_state;
    w_vec_nxt = r_vec;
    unique case (r_state)
      S_IDLE: if (w_start) begin
        w_nxt     = S_DRIVE;
        w_vec_nxt = 3'd0;
      end
      S_DRIVE:  w_nxt = S_SETTLE;
      S_SETTLE: if (r_settle == LP_LAST) w_nxt = S_CHECK;
      S_CHECK: begin
        if (r_vec == 3'd7) begin
          w_nxt = S_DONE;
        end else if (r_vec == 3'd3) begin
          w_nxt     = S_TURN;
          w_vec_nxt = 3'd4;
        end else begin
          w_nxt     = S_DRIVE;
          w_vec_nxt = r_vec + 3'd1;
        end
      end
      S_TURN: w_nxt = S_DRIVE;
      S_DONE: begin
        if (bus.mode) begin
          w_nxt     = S_DRIVE;
          w_vec_nxt = 3'd0;
        end else begin
          w_nxt = S_IDLE;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
    if (w_abort) begin
      w_nxt     = S_IDLE;
      w_vec_nxt = r_vec;
    end
  end

  // start edge flops reset high so a start held across reset is not a new edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_start     <= 1'b1;
      r_start_d   <= 1'b1;
      r_rx1       <= 2'd0;
      r_rx_s      <= 2'd0;
      r_vec       <= 3'd0;
      r_settle    <= 8'd0;
      r_tx        <= 2'd0;
      r_sel       <= 1'b0;
      r_err_cnt   <= 8'd0;
      r_fail_vec  <= 3'd0;
      r_first_err <= 1'b0;
      r_run_err   <= 1'b0;
      r_pass      <= 1'b0;
      r_ran       <= 1'b0;
    end else begin
      r_start   <= bus.start;
      r_start_d <= r_start;
      r_rx1     <= bus.rx_data;
      r_rx_s    <= r_rx1;
      r_vec     <= w_vec_nxt;
      r_settle  <= (r_state == S_SETTLE) ? r_settle + 8'd1 : 8'd0;
      if (w_nxt == S_DRIVE) begin
        r_tx  <= w_vec_nxt[1:0];
        r_sel <= w_vec_nxt[2];
      end
      if (r_state == S_IDLE && w_start) begin
        r_err_cnt   <= 8'd0;
        r_fail_vec  <= 3'd0;
        r_first_err <= 1'b0;
        r_run_err   <= 1'b0;
      end
      if (r_state == S_CHECK && !w_abort && w_mis) begin
        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
        r_run_err <= 1'b1;
        if (!r_first_err) begin
          r_fail_vec  <= r_vec;
          r_first_err <= 1'b1;
        end
      end
      if (r_state == S_DONE && !w_abort) begin
        r_pass <= ~r_run_err;
        r_ran  <= 1'b1;
        if (bus.mode) r_run_err <= 1'b0;
      end
    end
  end

  assign bus.tx_data  = r_tx;
  assign bus.sel      = r_sel;
  assign bus.drive_en = (r_state == S_DRIVE) ||
                        (r_state == S_SETTLE) ||
                        (r_state == S_CHECK);
  assign bus.busy     = r_state != S_IDLE;
  assign bus.done     = (r_state == S_DONE) & ~w_abort;
  assign bus.pass     = r_pass;
  assign bus.err_cnt  = r_err_cnt;
  assign bus.fail_vec = r_fail_vec;
  assign bus.led      = {r_err_cnt == 8'hFF, bus.busy,
                         ~r_pass & r_ran, r_pass & r_ran};

endmodule

// File: tb/tb_loopback_seq.sv
// tb_loopback_seq: randomized self-checking bench for loopback_seq
// with a per-vector fault table modelling the jumpered pads.
module tb_loopback_seq;
  localparam int S   = 4;
  localparam int RUN = 8 * (S + 2) + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] xr [8];
  int         n_checks = 0;
  int         n_fail   = 0;

  loopback_seq_if bus();

  loopback_seq #(.SETTLE_CYCLES(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // pad model: far end returns what was driven, corrupted per vector
  assign bus.rx_data = bus.tx_data ^ xr[{bus.sel, bus.tx_data}];

  function automatic int m_errs();
    int n = 0;
    for (int v = 0; v < 8; v++) if (xr[v] != 2'd0) n++;
    return n;
  endfunction

  function automatic logic [2:0] m_first();
    for (int v = 0; v < 8; v++) if (xr[v] != 2'd0) return 3'(v);
    return 3'd0;
  endfunction

  task automatic set_xr(input logic [1:0] a [8]);
    for (int v = 0; v < 8; v++) xr[v] = a[v];
  endtask

  task automatic clear_xr();
    for (int v = 0; v < 8; v++) xr[v] = 2'd0;
  endtask

  task automatic run_once(output int nb, output int nd);
    int n = 0;
    nb = 0;
    nd = 0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (!bus.busy && n < 10) begin @(negedge clk); n++; end
    while (bus.busy && n < 2000) begin
      nb++;
      if (bus.done) nd++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.start = 1'b0;
    bus.mode = 1'b0;
    bus.abort = 1'b0;
    clear_xr();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.tx_data, bus.sel, bus.drive_en, bus.busy, bus.done,
         bus.pass, bus.err_cnt, bus.fail_vec, bus.led} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got tx=%0d sel=%0d de=%0d busy=%0d done=%0d pass=%0d err=%0d fv=%0d led=%b, want all 0",
               bus.tx_data, bus.sel, bus.drive_en, bus.busy, bus.done,
               bus.pass, bus.err_cnt, bus.fail_vec, bus.led);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.drive_en, bus.led} !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_release_idle: busy=%0d de=%0d led=%b want 0",
               bus.busy, bus.drive_en, bus.led);
    end
  endtask

  task automatic test_clean();
    int nb = 0, nd = 0, n = 0;
    clear_xr();
    bus.start = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_latency_early: busy=%0d want 0", bus.busy);
    end
    bus.start = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.drive_en, bus.sel, bus.tx_data} !== 5'b11000) begin
      n_fail++;
      $display("FAIL start_latency: busy=%0d de=%0d sel=%0d tx=%0d want 1 1 0 0",
               bus.busy, bus.drive_en, bus.sel, bus.tx_data);
    end
    while (bus.busy && n < 2000) begin
      nb++;
      if (bus.done) nd++;
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (nb != RUN || nd != 1) begin
      n_fail++;
      $display("FAIL clean_timing: busy=%0d done=%0d want %0d 1", nb, nd, RUN);
    end
    n_checks++;
    if ({bus.pass, bus.err_cnt, bus.led} !== {1'b1, 8'd0, 4'b0001}) begin
      n_fail++;
      $display("FAIL clean_result: pass=%0d err=%0d led=%b want 1 0 0001",
               bus.pass, bus.err_cnt, bus.led);
    end
  endtask

  task automatic test_stuck();
    int nb, nd;
    logic [1:0] a [8];
    for (int v = 0; v < 8; v++) a[v] = (v % 2 == 1) ? 2'b01 : 2'b00;
    set_xr(a);
    run_once(nb, nd);
    n_checks++;
    if (bus.err_cnt !== 8'(m_errs()) || bus.fail_vec !== m_first()) begin
      n_fail++;
      $display("FAIL stuck_counts: err=%0d fv=%0d want %0d %0d",
               bus.err_cnt, bus.fail_vec, m_errs(), m_first());
    end
    n_checks++;
    if ({bus.pass, bus.led, nd[1:0]} !== {1'b0, 4'b0010, 2'd1}) begin
      n_fail++;
      $display("FAIL stuck_flags: pass=%0d led=%b done=%0d want 0 0010 1",
               bus.pass, bus.led, nd);
    end
  endtask

  task automatic test_turnaround();
    logic de [$];
    logic sl [$];
    logic [1:0] tx [$];
    int n = 0, k = -1, j = -1, ones = 0;
    clear_xr();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (!bus.busy && n < 10) begin @(negedge clk); n++; end
    while (bus.busy && n < 2000) begin
      de.push_back(bus.drive_en);
      sl.push_back(bus.sel);
      tx.push_back(bus.tx_data);
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < de.size(); i++) begin
      if (de[i]) ones++;
      if (de[i] && !sl[i] && tx[i] == 2'd3) k = i;
    end
    for (int i = de.size() - 1; i > k; i--) if (de[i]) j = i;
    n_checks++;
    if (ones != 8 * (S + 2)) begin
      n_fail++;
      $display("FAIL drive_cycles: got %0d want %0d", ones, 8 * (S + 2));
    end
    n_checks++;
    if (k < 0 || j < 0 || j - k != 2) begin
      n_fail++;
      $display("FAIL turn_gap: last_v3=%0d next_drive=%0d want gap 1", k, j);
    end else begin
      n_checks++;
      if ({sl[k + 1], sl[j], tx[j]} !== 4'b0100) begin
        n_fail++;
        $display("FAIL turn_sel: turn_sel=%0d sel=%0d tx=%0d want 0 1 0",
                 sl[k + 1], sl[j], tx[j]);
      end
    end
  endtask

  task automatic test_continuous();
    int nd = 0, n = 0;
    clear_xr();
    xr[6] = 2'b01;
    bus.mode = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (nd < 3 && n < 500) begin
      @(negedge clk);
      if (bus.done) nd++;
      n++;
    end
    repeat (10) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    bus.mode = 1'b0;
    n_checks++;
    if ({bus.busy, bus.drive_en} !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_idle: busy=%0d de=%0d want 0 0", bus.busy, bus.drive_en);
    end
    for (int i = 0; i < 60; i++) begin
      if (bus.done) nd++;
      @(negedge clk);
    end
    n_checks++;
    if (nd != 3) begin
      n_fail++;
      $display("FAIL cont_done: got %0d want 3", nd);
    end
    n_checks++;
    if ({bus.err_cnt, bus.fail_vec, bus.pass, bus.led} !==
        {8'(3 * m_errs()), m_first(), 1'b0, 4'b0010}) begin
      n_fail++;
      $display("FAIL cont_hold: err=%0d fv=%0d pass=%0d led=%b want %0d %0d 0 0010",
               bus.err_cnt, bus.fail_vec, bus.pass, bus.led, 3 * m_errs(), m_first());
    end
  endtask

  task automatic test_saturation();
    int nd = 0, n = 0, e;
    for (int v = 0; v < 8; v++) xr[v] = 2'b11;
    bus.mode = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (nd < 33 && n < 33 * RUN + 200) begin
      @(negedge clk);
      n++;
      if (bus.done) begin
        nd++;
        e = (nd * m_errs() > 255) ? 255 : nd * m_errs();
        if (nd == 1 || nd == 16 || nd == 32 || nd == 33) begin
          n_checks++;
          if (bus.err_cnt !== 8'(e)) begin
            n_fail++;
            $display("FAIL sat_count run%0d: err=%0d want %0d", nd, bus.err_cnt, e);
          end
        end
      end
    end
    n_checks++;
    if (nd != 33) begin
      n_fail++;
      $display("FAIL sat_runs: done=%0d want 33", nd);
    end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    bus.mode = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.err_cnt, bus.led} !== {8'hFF, 4'b1010}) begin
      n_fail++;
      $display("FAIL sat_led: err=%0d led=%b want 255 1010", bus.err_cnt, bus.led);
    end
  endtask

  task automatic test_reset_start_edge();
    int seen = 0;
    clear_xr();
    xr[0] = 2'b10;
    bus.start = 1'b1;
    repeat (9) @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.drive_en, bus.tx_data, bus.err_cnt} !== {4'b1101, 8'd1}) begin
      n_fail++;
      $display("FAIL pre_reset: busy=%0d de=%0d tx=%0d err=%0d want 1 1 1 1",
               bus.busy, bus.drive_en, bus.tx_data, bus.err_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.tx_data, bus.sel, bus.drive_en, bus.busy, bus.done,
         bus.pass, bus.err_cnt, bus.fail_vec, bus.led} !== 21'd0) begin
      n_fail++;
      $display("FAIL midrun_reset: tx=%0d sel=%0d de=%0d busy=%0d err=%0d led=%b want 0",
               bus.tx_data, bus.sel, bus.drive_en, bus.busy, bus.err_cnt, bus.led);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.busy) seen++;
      @(negedge clk);
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL held_start: busy cycles=%0d want 0", seen);
    end
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (bus.busy) seen++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    n_checks++;
    if (seen == 0) begin
      n_fail++;
      $display("FAIL retrigger: busy=%0d want run after toggle", seen);
    end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    int nb, nd, e;
    logic [2:0] f;
    for (int r = 0; r < 6; r++) begin
      for (int v = 0; v < 8; v++)
        xr[v] = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      e = m_errs();
      f = m_first();
      run_once(nb, nd);
      n_checks++;
      if (nb != RUN || nd != 1) begin
        n_fail++;
        $display("FAIL rand%0d_timing: busy=%0d done=%0d want %0d 1", r, nb, nd, RUN);
      end
      n_checks++;
      if ({bus.err_cnt, bus.fail_vec, bus.pass, bus.led} !==
          {8'(e), f, e == 0, 2'b00, e != 0, e == 0}) begin
        n_fail++;
        $display("FAIL rand%0d_result: err=%0d fv=%0d pass=%0d led=%b want %0d %0d %0d",
                 r, bus.err_cnt, bus.fail_vec, bus.pass, bus.led, e, f, e == 0);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean();
    test_stuck();
    test_turnaround();
    test_continuous();
    test_saturation();
    test_reset_start_edge();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
